// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port between an ALU
//               write-back source (A) and a load write-back source (B).
//               Round-robin arbitration uses valid/ready handshakes. A
//               registered write stage drives the register file, and a
//               per-register busy scoreboard is reserved at issue and
//               cleared at write-back acceptance.
//               Optional macro REGFILE_ARB_BYPASS_EN adds two bypass read
//               ports that expose the data being written this cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module regfile_wb_arbiter #(
    parameter int DW   = 19,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_data,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
`ifdef REGFILE_ARB_BYPASS_EN
    input  logic [AW-1:0]   byp_ra1,
    input  logic [AW-1:0]   byp_ra2,
    output logic            byp_hit1,
    output logic            byp_hit2,
    output logic [DW-1:0]   byp_data1,
    output logic [DW-1:0]   byp_data2,
`endif
    output logic [NREG-1:0] busy,
    output logic            wb_unexp,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [DW-1:0]   rf_wd,
    output logic            rf_src
);

    // Round-robin pointer: 0 = A won the last contention, 1 = B did.
    logic            last_grant_q;
    logic            last_grant_d;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            unexp_q;
    logic            unexp_d;

    logic            rf_we_q;
    logic [AW-1:0]   rf_wa_q;
    logic [DW-1:0]   rf_wd_q;
    logic            rf_src_q;

    logic            w_gnt_a;
    logic            w_gnt_b;
    logic            w_xfer;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_data;

    // Grant: a lone requester always wins; on contention the source that did
    // not win last time wins. Ready depends only on valids, pointer and rst.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                w_gnt_a = last_grant_q;
                w_gnt_b = !last_grant_q;
            end else begin
                w_gnt_a = a_valid;
                w_gnt_b = b_valid;
            end
        end
    end

    assign a_ready    = w_gnt_a;
    assign b_ready    = w_gnt_b;
    assign w_xfer     = w_gnt_a || w_gnt_b;
    assign w_win_addr = w_gnt_b ? b_addr : a_addr;
    assign w_win_data = w_gnt_b ? b_data : a_data;

    // Pointer only moves when both sources competed, so the loser is next.
    always_comb begin
        last_grant_d = last_grant_q;
        if (!rst && a_valid && b_valid) begin
            last_grant_d = w_gnt_b;
        end
    end

    // Scoreboard next state: clear on accepted write-back, then apply the
    // reservation so a same-register set overrides the clear.
    always_comb begin
        busy_d = busy_q;
        if (w_xfer) begin
            busy_d[w_win_addr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
        unexp_d = w_xfer && !busy_q[w_win_addr];
    end

    // Arbitration pointer and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            busy_q       <= '0;
            unexp_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            unexp_q      <= unexp_d;
        end
    end

    // Write stage: capture the winning transfer; address/data/source hold
    // when idle so the regfile inputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
            rf_src_q <= 1'b0;
        end else begin
            rf_we_q <= w_xfer;
            if (w_xfer) begin
                rf_wa_q  <= w_win_addr;
                rf_wd_q  <= w_win_data;
                rf_src_q <= w_gnt_b;
            end
        end
    end

    assign busy     = busy_q;
    assign wb_unexp = unexp_q;
    assign rf_we    = rf_we_q;
    assign rf_wa    = rf_wa_q;
    assign rf_wd    = rf_wd_q;
    assign rf_src   = rf_src_q;

`ifdef REGFILE_ARB_BYPASS_EN
    // The regfile read still returns the old value until the write edge, so
    // decode takes the in-flight write data on an address match.
    assign byp_hit1  = rf_we_q && (rf_wa_q == byp_ra1);
    assign byp_hit2  = rf_we_q && (rf_wa_q == byp_ra2);
    assign byp_data1 = rf_wd_q;
    assign byp_data2 = rf_wd_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter: directed vector
//               table, hand sequences for corner cases, randomized traffic
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_regfile_wb_arbiter;

    localparam int DW   = 19;
    localparam int AW   = 3;
    localparam int NREG = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, a_ready, b_valid, b_ready, rsv_valid;
    logic [AW-1:0]   a_addr, b_addr, rsv_addr;
    logic [DW-1:0]   a_data, b_data;
    logic [NREG-1:0] busy;
    logic            wb_unexp, rf_we, rf_src;
    logic [AW-1:0]   rf_wa;
    logic [DW-1:0]   rf_wd;
`ifdef REGFILE_ARB_BYPASS_EN
    logic [AW-1:0]   byp_ra1, byp_ra2;
    logic            byp_hit1, byp_hit2;
    logic [DW-1:0]   byp_data1, byp_data2;
`endif

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
`ifdef REGFILE_ARB_BYPASS_EN
        .byp_ra1(byp_ra1), .byp_ra2(byp_ra2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
        .busy(busy), .wb_unexp(wb_unexp),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_src(rf_src)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: transaction-level view of the arbiter.
    bit              m_b_won_last;   // who won the last contention
    bit              m_busy [NREG];
    bit              m_we, m_src, m_unexp;
    logic [AW-1:0]   m_wa;
    logic [DW-1:0]   m_wd;

    typedef struct {
        bit            av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        bit            bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        bit            rv;
        logic [AW-1:0] ra;
        bit            exp_ar;
        bit            exp_br;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_busy_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         input bit rv, input logic [AW-1:0] ra);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rsv_valid = rv; rsv_addr = ra;
    endtask

    // One clock: check handshake against the model, advance the model on the
    // edge, then check every registered output.
    task automatic tick(output bit ga, output bit gb);
        bit            win_b, xfer;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        #2;
        ga = 1'b0; gb = 1'b0;
        if (!rst) begin
            if (a_valid && !b_valid)      ga = 1'b1;
            else if (b_valid && !a_valid) gb = 1'b1;
            else if (a_valid && b_valid) begin
                if (m_b_won_last) ga = 1'b1; else gb = 1'b1;
            end
        end
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        xfer  = ga || gb;
        win_b = gb;
        waddr = gb ? b_addr : a_addr;
        wdata = gb ? b_data : a_data;
        @(posedge clk);
        if (rst) begin
            m_b_won_last = 1'b1;
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            m_we = 0; m_wa = '0; m_wd = '0; m_src = 0; m_unexp = 0;
        end else begin
            if (a_valid && b_valid) m_b_won_last = win_b;
            m_unexp = xfer && !m_busy[waddr];
            m_we    = xfer;
            if (xfer) begin
                m_wa = waddr; m_wd = wdata; m_src = win_b;
                m_busy[waddr] = 1'b0;
            end
            if (rsv_valid) m_busy[rsv_addr] = 1'b1;
        end
        #1;
        chk("rf_we", rf_we, m_we);
        chk("rf_wa", rf_wa, m_wa);
        chk("rf_wd", rf_wd, m_wd);
        chk("rf_src", rf_src, m_src);
        chk("busy", busy, model_busy_vec());
        chk("wb_unexp", wb_unexp, m_unexp);
`ifdef REGFILE_ARB_BYPASS_EN
        byp_ra1 = AW'($urandom);
        byp_ra2 = AW'($urandom);
        #1;
        chk("byp_hit1", byp_hit1, m_we && (m_wa == byp_ra1));
        chk("byp_hit2", byp_hit2, m_we && (m_wa == byp_ra2));
        chk("byp_data1", byp_data1, m_wd);
        chk("byp_data2", byp_data2, m_wd);
`endif
    endtask

    vec_t vecs [12];
    bit   ga, gb;
    bit            pa, pb;
    logic [AW-1:0] qa, qb;
    logic [DW-1:0] da, db;

    initial begin
        // Directed table: issue sequence, single write, contention, fairness.
        vecs[0]  = '{0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     1, 3'd3, 0, 0};
        vecs[1]  = '{1, 3'd3, 19'h12345, 0, 3'd0, 19'h0,     0, 3'd0, 1, 0};
        vecs[2]  = '{0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     1, 3'd1, 0, 0};
        vecs[3]  = '{0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     1, 3'd2, 0, 0};
        vecs[4]  = '{1, 3'd1, 19'h00001, 1, 3'd2, 19'h7FFFF, 0, 3'd0, 1, 0};
        vecs[5]  = '{1, 3'd1, 19'h00011, 1, 3'd2, 19'h7FFFF, 0, 3'd0, 0, 1};
        vecs[6]  = '{1, 3'd1, 19'h00011, 1, 3'd5, 19'h00222, 0, 3'd0, 1, 0};
        vecs[7]  = '{1, 3'd6, 19'h00333, 1, 3'd5, 19'h00222, 0, 3'd0, 0, 1};
        vecs[8]  = '{1, 3'd6, 19'h00333, 1, 3'd7, 19'h00444, 0, 3'd0, 1, 0};
        vecs[9]  = '{1, 3'd0, 19'h00555, 1, 3'd7, 19'h00444, 0, 3'd0, 0, 1};
        vecs[10] = '{1, 3'd0, 19'h00555, 0, 3'd0, 19'h0,     0, 3'd0, 1, 0};
        vecs[11] = '{0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     0, 3'd0, 0, 0};

        rst = 1'b1;
        drive(1, 3'd1, 19'h1, 1, 3'd2, 19'h2, 0, 3'd0);
`ifdef REGFILE_ARB_BYPASS_EN
        byp_ra1 = '0; byp_ra2 = '0;
`endif
        @(posedge clk); #2;

        // Reset held two cycles with both sources requesting.
        for (int i = 0; i < 2; i++) begin
            tick(ga, gb);
            chk("rst_rf_we", rf_we, 0);
            chk("rst_busy", busy, 8'h00);
        end
        rst = 1'b0;
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd,
                  vecs[i].rv, vecs[i].ra);
            tick(ga, gb);
            chk("tbl_a_ready", ga, vecs[i].exp_ar);
            chk("tbl_b_ready", gb, vecs[i].exp_br);
            if (i == 1) begin
                chk("single_rf_wd", rf_wd, 19'h12345);
                chk("single_busy3", busy[3], 0);
            end
        end

        // Scoreboard corner: set and clear of r5 in one cycle, set wins.
        drive(0, 3'd0, 19'h0, 0, 3'd0, 19'h0, 1, 3'd5); tick(ga, gb);
        drive(0, 3'd0, 19'h0, 1, 3'd5, 19'h00055, 1, 3'd5); tick(ga, gb);
        chk("corner_busy5", busy[5], 1);
        drive(1, 3'd6, 19'h00066, 0, 3'd0, 19'h0, 0, 3'd0); tick(ga, gb);
        chk("corner_unexp_hi", wb_unexp, 1);
        drive(0, 3'd0, 19'h0, 0, 3'd0, 19'h0, 0, 3'd0); tick(ga, gb);
        chk("corner_unexp_lo", wb_unexp, 0);

`ifdef REGFILE_ARB_BYPASS_EN
        drive(1, 3'd4, 19'h0ABCD, 0, 3'd0, 19'h0, 0, 3'd0); tick(ga, gb);
        byp_ra1 = 3'd4; byp_ra2 = 3'd2; #1;
        chk("byp_hit1_dir", byp_hit1, 1);
        chk("byp_data1_dir", byp_data1, 19'h0ABCD);
        chk("byp_hit2_dir", byp_hit2, 0);
        drive(0, 3'd0, 19'h0, 0, 3'd0, 19'h0, 0, 3'd0); tick(ga, gb);
`endif

        // Reset mid-operation cancels the registered write and the scoreboard.
        drive(0, 3'd0, 19'h0, 0, 3'd0, 19'h0, 1, 3'd2); tick(ga, gb);
        drive(1, 3'd3, 19'h00777, 0, 3'd0, 19'h0, 0, 3'd0); tick(ga, gb);
        rst = 1'b1;
        drive(1, 3'd4, 19'h00888, 1, 3'd1, 19'h00999, 0, 3'd0); tick(ga, gb);
        chk("midrst_rf_we", rf_we, 0);
        chk("midrst_busy", busy, 8'h00);
        rst = 1'b0;

        // Random traffic; losers hold their request until accepted.
        pa = 0; pb = 0; qa = '0; qb = '0; da = '0; db = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && ($urandom_range(0, 2) != 0)) begin
                pa = 1; qa = AW'($urandom); da = DW'($urandom);
            end
            if (!pb && ($urandom_range(0, 2) != 0)) begin
                pb = 1; qb = AW'($urandom); db = DW'($urandom);
            end
            rst = ($urandom_range(0, 49) == 0);
            drive(pa, qa, da, pb, qb, db, $urandom_range(0, 1) == 1, AW'($urandom));
            tick(ga, gb);
            if (ga || rst) pa = 0;
            if (gb || rst) pb = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two write-back sources:
  - Source A: ALU result.
  - Source B: load/memory result.
- Round-robin arbitration with valid/ready handshakes.
- Registered write stage that drives rf_we/rf_wa/rf_wd straight into the register file.
- Per-register busy scoreboard: the issue stage reserves destinations; write-back clears them, and decode uses busy to stall on RAW hazards.

Parameters:
- DW, 19, data width of write-back data and register contents.
- AW, 3, register address width.
- NREG, 8, number of registers; must equal 2**AW.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- a_valid  in  1  source A has a write-back pending.
- a_ready  out  1  source A write accepted this cycle.
- a_addr  in  AW  source A destination register.
- a_data  in  DW  source A write data.
- b_valid  in  1  source B has a write-back pending.
- b_ready  out  1  source B write accepted this cycle.
- b_addr  in  AW  source B destination register.
- b_data  in  DW  source B write data.
- rsv_valid  in  1  issue stage reserves a destination this cycle.
- rsv_addr  in  AW  register being reserved.
- busy  out  NREG  bit r = 1 while register r has an outstanding write.
- wb_unexp  out  1  one-cycle pulse: accepted write targeted a non-busy register.
- rf_we  out  1  register-file write enable.
- rf_wa  out  AW  register-file write address.
- rf_wd  out  DW  register-file write data.
- rf_src  out  1  source of the current rf write (0 = A, 1 = B).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Nothing is reset asynchronously.
- Reset values:
  - rf_we=0, rf_wa=0, rf_wd=0, rf_src=0.
  - busy=0, wb_unexp=0.
  - Round-robin pointer last_grant=B, so A wins the first contention.
  - a_ready=b_ready=0 while rst is high.
- Handshake:
  - A transfer occurs when valid && ready.
  - ready is combinational from valid, the pointer and rst. It never depends on same-cycle ready of the other source.
  - The write stage accepts one transfer every cycle (regfile never back-pressures), so at least one ready is high whenever any valid is high and rst=0.
- Arbitration:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source that is not last_grant; last_grant updates to the winner.
  - Loser holds valid, addr and data stable until accepted. It is guaranteed to win next cycle, so wait is at most 1 cycle.
- Write stage (latency 1 cycle, handshake cycle N -> regfile write at posedge ending N+1):
  - On a transfer: rf_we<=1, rf_wa<=winner addr, rf_wd<=winner data, rf_src<=winner id.
  - No transfer: rf_we<=0; rf_wa/rf_wd/rf_src hold.
- Same-address contention: both sources targeting register r are serialized in grant order; the later grant's data is the final value.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] next cycle.
  - An accepted transfer to r clears busy[r] next cycle (at handshake, not at rf write).
  - Set and clear of the same r in the same cycle: set wins, busy[r]=1.
  - Set on an already-busy r: stays 1 (single-outstanding model; issue must not do this).
  - Accepted transfer to a non-busy register: the write proceeds normally; wb_unexp pulses 1 the next cycle.
  - Set and clear of different registers in the same cycle both apply.
- Reset mid-operation:
  - Any pending valid is dropped (ready=0).
  - A write already registered in rf_we is cancelled: rf_we=0 next cycle.
  - busy clears.

Optional Feature:
- Macro: REGFILE_ARB_BYPASS_EN.
- Defined:
  - Adds inputs byp_ra1, byp_ra2 (AW each).
  - Adds outputs byp_hit1, byp_hit2 (1 each) and byp_data1, byp_data2 (DW each).
  - byp_hitN = rf_we && (rf_wa == byp_raN), combinational; byp_dataN = rf_wd.
  - Lets decode use data being written this cycle, since the regfile async read still returns the old value until the edge.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_we=0, busy=8'h00.
- Single source: rsv r3; next cycle A writes r3=19'h12345 -> a_ready=1; next cycle rf_we=1, rf_wa=3, rf_wd=19'h12345, rf_src=0; busy[3]=0.
- Contention: both valid, A to r1=19'h00001, B to r2=19'h7FFFF, both reserved -> cycle 0 grants A, cycle 1 grants B; rf writes r1 then r2; busy=0 after.
- Fairness: both held valid for 6 cycles -> grants alternate A,B,A,B,A,B; no source waits more than 1 cycle.
- Scoreboard corner: busy[5]=1; in one cycle rsv_addr=5 and B writes r5 -> busy[5]=1 after. Then A writes non-busy r6 -> wb_unexp=1 for exactly one cycle.
- Bypass (macro defined): A writes r4=19'h0ABCD, byp_ra1=4 in the rf_we cycle -> byp_hit1=1, byp_data1=19'h0ABCD; byp_ra2=2 -> byp_hit2=0.
